// File: rtl/serial_to_parallel.sv
// MSB-first serial-to-parallel deserializer for the MRAM-FPGA link.
// Completed words land in a holding register guarded by a ready/ack handshake.
module serial_to_parallel #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clear,
   input  logic             rx_valid,
   input  logic             rx_bit,
   output logic [WIDTH-1:0] data_out,
   output logic             data_ready,
   input  logic             data_ack,
   output logic             busy,
   output logic [CNT_W-1:0] bit_count,
   output logic             overrun
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   logic [0:0]       state;
   logic [0:0]       state_nxt;
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] word_nxt;
   logic             last_bit;
   logic             can_load;

   // Handshake: data_ready is the valid, data_ack the ready; a word is
   // consumed on an edge where both are high. A completing word may load on
   // that same edge, otherwise a completion with data_ready=1 is dropped.
   always_comb begin
      word_nxt  = {shift_reg[WIDTH-2:0], rx_bit};
      last_bit  = rx_valid && (bit_count == CNT_W'(WIDTH - 1));
      can_load  = !data_ready || data_ack;
      state_nxt = state;
      if (rx_valid) begin
         state_nxt = last_bit ? IDLE : SHIFT;
      end
   end

   assign busy = (state == SHIFT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         shift_reg  <= '0;
         bit_count  <= '0;
         data_out   <= '0;
         data_ready <= 1'b0;
         overrun    <= 1'b0;
      end else if (en) begin
         if (clear) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_count  <= '0;
            data_out   <= '0;
            data_ready <= 1'b0;
            overrun    <= 1'b0;
         end else begin
            state <= state_nxt;
            if (rx_valid) begin
               if (last_bit) begin
                  shift_reg <= '0;
                  bit_count <= '0;
               end else begin
                  shift_reg <= word_nxt;
                  bit_count <= bit_count + 1'b1;
               end
            end
            if (last_bit) begin
               if (can_load) begin
                  data_out   <= word_nxt;
                  data_ready <= 1'b1;
               end else begin
                  overrun <= 1'b1;
               end
            end else if (data_ack && data_ready) begin
               data_ready <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_to_parallel.sv
// Self-checking bench for serial_to_parallel: directed link scenarios plus
// randomized words with gaps, checked against an expected-word queue.
module tb_serial_to_parallel;
   localparam int W = 16;
   localparam int CW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          en = 1'b1;
   logic          clear = 1'b0;
   logic          rx_valid = 1'b0;
   logic          rx_bit = 1'b0;
   logic [W-1:0]  data_out;
   logic          data_ready;
   logic          data_ack = 1'b0;
   logic          busy;
   logic [CW-1:0] bit_count;
   logic          overrun;

   logic [W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   serial_to_parallel #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .en(en), .clear(clear),
      .rx_valid(rx_valid), .rx_bit(rx_bit),
      .data_out(data_out), .data_ready(data_ready), .data_ack(data_ack),
      .busy(busy), .bit_count(bit_count), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Pop the expected word and compare it against the holding register.
   task automatic sb_check(input string tag);
      logic [W-1:0] exp;
      if (exp_q.size() == 0) begin
         check({tag, "_queue_empty"}, 32'(exp_q.size()), 1);
      end else begin
         exp = exp_q.pop_front();
         check({tag, "_data"}, 32'(data_out), 32'(exp));
         check({tag, "_ready"}, 32'(data_ready), 1);
         check({tag, "_busy"}, 32'(busy), 0);
         check({tag, "_count"}, 32'(bit_count), 0);
      end
   endtask

   // Drive bit positions first..last (0 = MSB); optional idle gaps after given bit counts.
   task automatic send_bits(input logic [W-1:0] w, input int first, input int last,
                            input int gap_a, input int gap_b, input int gap_len,
                            input bit ack_last);
      for (int k = first; k <= last; k++) begin
         rx_valid = 1'b1;
         rx_bit   = w[W-1-k];
         data_ack = ack_last && (k == W - 1);
         tick();
         rx_valid = 1'b0;
         data_ack = 1'b0;
         if ((k + 1 == gap_a || k + 1 == gap_b) && k < W - 1) begin
            for (int g = 0; g < gap_len; g++) begin
               tick();
               check("gap_count", 32'(bit_count), 32'(k + 1));
               check("gap_busy", 32'(busy), 1);
            end
         end
      end
   endtask

   task automatic send_word(input logic [W-1:0] w, input bit push, input int gap_a,
                            input int gap_b, input int gap_len, input bit ack_last,
                            input string tag);
      if (push) exp_q.push_back(w);
      send_bits(w, 0, W - 1, gap_a, gap_b, gap_len, ack_last);
      if (push) sb_check(tag);
   endtask

   task automatic ack_word(input logic [W-1:0] held);
      data_ack = 1'b1;
      tick();
      data_ack = 1'b0;
      check("ack_ready", 32'(data_ready), 0);
      check("ack_hold", 32'(data_out), 32'(held));
   endtask

   initial begin
      logic [W-1:0] rw;
      rst = 1'b1;
      #12;
      check("rst_data", 32'(data_out), 0);
      check("rst_ready", 32'(data_ready), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_count", 32'(bit_count), 0);
      check("rst_overrun", 32'(overrun), 0);
      rst = 1'b0;
      tick();

      // 1: plain word
      exp_q.push_back(16'hA5C3);
      send_bits(16'hA5C3, 0, 0, 0, 0, 0, 1'b0);
      check("t1_busy_first", 32'(busy), 1);
      check("t1_count_first", 32'(bit_count), 1);
      send_bits(16'hA5C3, 1, W - 1, 0, 0, 0, 1'b0);
      sb_check("t1");
      check("t1_overrun", 32'(overrun), 0);
      ack_word(16'hA5C3);
      data_ack = 1'b1;
      tick();
      data_ack = 1'b0;
      check("t1_stray_ack", 32'(data_ready), 0);

      // 2: gaps after bits 4 and 11
      send_word(16'h8001, 1'b1, 4, 11, 3, 1'b0, "t2");
      ack_word(16'h8001);

      // 3: back-to-back, ack on the second completion edge
      send_word(16'h1234, 1'b1, 0, 0, 0, 1'b0, "t3a");
      send_word(16'hFFFF, 1'b1, 0, 0, 0, 1'b1, "t3b");
      check("t3_overrun", 32'(overrun), 0);
      ack_word(16'hFFFF);

      // 4: overrun drops the second word
      send_word(16'h1234, 1'b1, 0, 0, 0, 1'b0, "t4a");
      send_word(16'h5678, 1'b0, 0, 0, 0, 1'b0, "t4b");
      check("t4_keep", 32'(data_out), 32'h1234);
      check("t4_overrun", 32'(overrun), 1);
      check("t4_ready", 32'(data_ready), 1);
      ack_word(16'h1234);
      check("t4_sticky", 32'(overrun), 1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("t4_clr_overrun", 32'(overrun), 0);
      check("t4_clr_data", 32'(data_out), 0);

      // 5: clear wins over rx_valid mid-word
      send_bits(16'hFFFF, 0, 6, 0, 0, 0, 1'b0);
      check("t5_count7", 32'(bit_count), 7);
      clear = 1'b1;
      rx_valid = 1'b1;
      rx_bit = 1'b1;
      tick();
      clear = 1'b0;
      rx_valid = 1'b0;
      check("t5_count", 32'(bit_count), 0);
      check("t5_busy", 32'(busy), 0);
      check("t5_ready", 32'(data_ready), 0);
      send_word(16'h00FF, 1'b1, 0, 0, 0, 1'b0, "t5");
      ack_word(16'h00FF);

      // 6a: en=0 freezes everything mid-word
      exp_q.push_back(16'hC3A5);
      send_bits(16'hC3A5, 0, 5, 0, 0, 0, 1'b0);
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rx_valid = 1'($urandom_range(0, 1));
         rx_bit   = 1'($urandom_range(0, 1));
         clear    = 1'($urandom_range(0, 1));
         tick();
         check("t6_frozen", 32'(bit_count), 6);
      end
      en = 1'b1;
      rx_valid = 1'b0;
      clear = 1'b0;
      send_bits(16'hC3A5, 6, W - 1, 0, 0, 0, 1'b0);
      sb_check("t6");
      ack_word(16'hC3A5);

      // 6b: asynchronous reset mid-word
      send_bits(16'hBEEF, 0, 4, 0, 0, 0, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_count", 32'(bit_count), 0);
      check("t6_rst_busy", 32'(busy), 0);
      check("t6_rst_data", 32'(data_out), 0);
      check("t6_rst_ready", 32'(data_ready), 0);
      check("t6_rst_overrun", 32'(overrun), 0);
      rst = 1'b0;
      tick();

      // randomized words with random gaps
      for (int n = 0; n < 8; n++) begin
         rw = W'($urandom_range(0, 65535));
         send_word(rw, 1'b1, $urandom_range(1, 15), $urandom_range(1, 15),
                   $urandom_range(0, 3), 1'b0, "rand");
         ack_word(rw);
      end

      check("final_queue_empty", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/serial_to_parallel.md
Name: serial_to_parallel

Overview:
Receive-side deserializer for the MRAM-FPGA serial data link. It samples one bit per rx_valid strobe, MSB first, and assembles WIDTH-bit words. Each completed word goes into a double-buffered output register with a ready/ack handshake. It is the counterpart of the link's parallel-in/serial-out transmitter and returns serialized MRAM words to parallel form for downstream logic.

Parameters:
WIDTH, 16, word length in bits (≥2)
CNT_W, 5, bit-counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
en  input  1  block enable; when low all state frozen
clear  input  1  synchronous abort/flush (active when en=1)
rx_valid  input  1  qualifies rx_bit this cycle
rx_bit  input  1  serial data bit, MSB first
data_out  output  WIDTH  last completed word (holding register)
data_ready  output  1  data_out holds an unconsumed word
data_ack  input  1  consumer accepts data_out this cycle
busy  output  1  partial word in progress (state SHIFT)
bit_count  output  CNT_W  bits received in the current word, 0..WIDTH-1
overrun  output  1  sticky: a completed word was dropped

Behaviour:
- Reset (rst=1, async): shift_reg=0, bit_count=0, state=IDLE, data_out=0, data_ready=0, busy=0, overrun=0.
- en=0: no register changes; rx_valid, data_ack and clear are ignored.
- Priority with en=1: clear > rx_valid/data_ack.
- clear: on the next edge shift_reg=0, bit_count=0, state=IDLE, data_ready=0, overrun=0, data_out=0. The rx_bit presented in the same cycle is discarded.
- Shift: each edge with rx_valid=1 does shift_reg <= {shift_reg[WIDTH-2:0], rx_bit} and bit_count+1. The first received bit ends up in data_out[WIDTH-1].
- FSM: 2 states.
  - IDLE (bit_count=0, busy=0): rx_valid moves to SHIFT and captures bit 0. For WIDTH≥2 the state is SHIFT after that edge.
  - SHIFT (busy=1): rx_valid while bit_count=WIDTH-1 completes the word.
  - Completion returns to IDLE, bit_count=0, shift_reg=0.
- Gaps: rx_valid may drop for any number of cycles mid-word. State and count hold. There is no timeout.
- Completion latency: data_out and data_ready update on the same edge that samples the WIDTH-th bit, so both are visible the cycle after the last rx_valid.
- Handshake:
  - data_ready stays high until an edge with data_ack=1 and data_ready=1, then drops to 0.
  - data_out keeps its value after ack and only changes on the next completion.
  - data_ack while data_ready=0 has no effect.
- Simultaneous completion and ack (data_ready=1): the ack consumes the old word, the new word loads into data_out, and data_ready stays 1. No overrun.
- Completion while data_ready=1 without ack:
  - The new word is discarded; data_out keeps the old word.
  - overrun is set to 1 and stays set until clear or rst.
  - Shift state still returns to IDLE, so reception continues.
- Back-to-back: completion and the first bit of the next word can occur on consecutive edges with no dead cycle.
- Reset mid-word: partial data is lost immediately, with no word emitted.
- Link timing: the transmitter presents each bit one cycle after its shift strobe. At system level, rx_valid is that strobe delayed by one clk.

Test Plan:
1. Reset, en=1, then 16 consecutive rx_valid carrying 0xA5C3 MSB first -> data_out=0xA5C3, data_ready=1 the cycle after the 16th bit, busy=0, bit_count=0, overrun=0.
2. Send 0x8001 with rx_valid deasserted for 3 cycles after bits 4 and 11 -> bit_count holds during the gaps (4, then 11); data_out=0x8001 at completion.
3. Send 0x1234 then 0xFFFF back-to-back, pulsing data_ack on the 0xFFFF completion edge -> data_out goes 0x1234 then 0xFFFF, data_ready stays 1, overrun=0.
4. Send 0x1234, no ack, then 0x5678 -> data_out stays 0x1234, overrun=1. Then ack -> data_ready=0. Then clear -> overrun=0, data_out=0.
5. After 7 bits, pulse clear together with rx_valid -> bit_count=0, busy=0. A fresh 16-bit 0x00FF then completes correctly.
6. Mid-word: hold en=0 for 5 cycles while toggling rx_valid/rx_bit, then resume -> frozen bits ignored and the word is correct. Separately, assert rst asynchronously mid-word -> all outputs 0 immediately.
